scene_renderer: RTL and testbench

//  Pixel source for the 800x600 SVGA output stage. Consumes that stage's X/Y counters and

---
 rtl/scene_renderer.sv | 222 ++++++++++++++++++++++
 tb/tb_scene_renderer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scene_renderer.sv
// Pixel source for the 800x600 SVGA output stage: ball, paddle, brick grid and background.
// Object state lives in frame-shadowed registers. Define SCENE_RENDERER_BORDER_EN to add an 8 px border.
module scene_renderer #(
   parameter int unsigned BRICK_ROWS   = 8,
   parameter int unsigned BRICK_TOP    = 40,
   parameter int unsigned BRICK_W      = 50,
   parameter int unsigned BRICK_H      = 20,
   parameter int unsigned PADDLE_W     = 80,
   parameter int unsigned PADDLE_Y     = 560,
   parameter int unsigned BALL_SIZE    = 8,
   parameter logic [7:0]  BG_COLOR     = 8'h00,
   parameter logic [7:0]  PADDLE_COLOR = 8'hFF,
   parameter logic [7:0]  BALL_COLOR   = 8'hFC,
   parameter logic [7:0]  BORDER_COLOR = 8'h92,
   parameter int unsigned LINE_END     = 1056,
   parameter int unsigned FRAME_END    = 628,
   parameter int unsigned VIS_X        = 800,
   parameter int unsigned VIS_Y        = 600
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [10:0]                x_pixel_i,
   input  logic [9:0]                 y_pixel_i,
   input  logic                       frame_start_i,
   input  logic [9:0]                 paddle_x_i,
   input  logic [9:0]                 ball_x_i,
   input  logic [9:0]                 ball_y_i,
   input  logic [BRICK_ROWS*16-1:0]   bricks_i,
   input  logic                       commit_i,
   output logic                       pending_o,
   output logic                       applied_o,
   output logic [7:0]                 color_o
);

   localparam int unsigned X_W      = 11;
   localparam int unsigned Y_W      = 10;
   localparam int unsigned NB       = BRICK_ROWS * 16;
   localparam int unsigned IDX_W    = $clog2(NB);
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned PADDLE_H = 10;
   localparam int unsigned BORDER_W = 8;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic             pending_q, pending_d;
   logic             applied_q, applied_d;
   logic             shadow_load;
   logic [7:0]       color_q, color_d;

   logic [9:0]       paddle_x_q, paddle_x_d;
   logic [9:0]       ball_x_q, ball_x_d;
   logic [9:0]       ball_y_q, ball_y_d;
   logic [NB-1:0]    bricks_q, bricks_d;

   logic [CNT_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] xoff_q, xoff_d;
   logic [CNT_W-1:0] row_q, row_d;
   logic [CNT_W-1:0] yoff_q, yoff_d;

   logic             line_wrap;
   logic [X_W-1:0]   nx;
   logic [Y_W-1:0]   ny;
   logic [X_W-1:0]   ny_ext;
   logic             visible;
   logic             ball_hit;
   logic             paddle_hit;
   logic             in_band;
   logic [IDX_W-1:0] brick_idx;
   logic             brick_hit;
   logic [7:0]       brick_color;
   logic             border_hit;

   // Lookahead: the pixel the output stage will show next cycle
   always_comb begin
      line_wrap = (x_pixel_i == X_W'(LINE_END - 1));
      nx        = x_pixel_i + X_W'(1);
      ny        = y_pixel_i;
      if (line_wrap) begin
         nx = '0;
         ny = (y_pixel_i == Y_W'(FRAME_END - 1)) ? '0 : y_pixel_i + Y_W'(1);
      end
   end

   // Brick column/row tracking; relies on the output stage counting pixels one at a time
   always_comb begin
      col_d  = col_q;
      xoff_d = xoff_q;
      row_d  = row_q;
      yoff_d = yoff_q;
      if (line_wrap) begin
         col_d  = '0;
         xoff_d = '0;
         if (ny == Y_W'(BRICK_TOP)) begin
            row_d  = '0;
            yoff_d = '0;
         end else if (yoff_q == CNT_W'(BRICK_H - 1)) begin
            row_d  = row_q + CNT_W'(1);
            yoff_d = '0;
         end else begin
            yoff_d = yoff_q + CNT_W'(1);
         end
      end else if (xoff_q == CNT_W'(BRICK_W - 1)) begin
         col_d  = col_q + CNT_W'(1);
         xoff_d = '0;
      end else begin
         xoff_d = xoff_q + CNT_W'(1);
      end
   end

   // Object hit tests on the lookahead pixel; sums are 11 bits so nothing wraps
   always_comb begin
      ny_ext     = {1'b0, ny};
      visible    = (nx < X_W'(VIS_X)) && (ny < Y_W'(VIS_Y));
      ball_hit   = (nx >= {1'b0, ball_x_q}) && (nx < ({1'b0, ball_x_q} + X_W'(BALL_SIZE))) &&
                   (ny_ext >= {1'b0, ball_y_q}) && (ny_ext < ({1'b0, ball_y_q} + X_W'(BALL_SIZE)));
      paddle_hit = (nx >= {1'b0, paddle_x_q}) && (nx < ({1'b0, paddle_x_q} + X_W'(PADDLE_W))) &&
                   (ny >= Y_W'(PADDLE_Y)) && (ny < Y_W'(PADDLE_Y + PADDLE_H));
      in_band    = (ny >= Y_W'(BRICK_TOP)) && (ny < Y_W'(BRICK_TOP + BRICK_ROWS * BRICK_H));
      brick_idx  = IDX_W'({row_d, col_d[3:0]});
      brick_hit  = in_band && bricks_q[brick_idx] &&
                   (xoff_d < CNT_W'(BRICK_W - 2)) && (yoff_d < CNT_W'(BRICK_H - 2));
      brick_color = {row_d[2:0], 3'b111 - row_d[2:0], 2'b10};
   end

`ifdef SCENE_RENDERER_BORDER_EN
   assign border_hit = (nx < X_W'(BORDER_W)) || (nx >= X_W'(VIS_X - BORDER_W)) ||
                       (ny < Y_W'(BORDER_W));
`else
   assign border_hit = 1'b0;
`endif

   // Layer priority: ball > paddle > brick > border > background
   always_comb begin
      color_d = BG_COLOR;
      if (!visible) begin
         color_d = '0;
      end else if (ball_hit) begin
         color_d = BALL_COLOR;
      end else if (paddle_hit) begin
         color_d = PADDLE_COLOR;
      end else if (brick_hit) begin
         color_d = brick_color;
      end else if (border_hit) begin
         color_d = BORDER_COLOR;
      end
   end

   // Commit handshake: staged inputs are taken at the frame boundary, never mid-frame
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      applied_d   = 1'b0;
      shadow_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (commit_i && frame_start_i) begin
               shadow_load = 1'b1;
               applied_d   = 1'b1;
            end else if (commit_i) begin
               state_d   = ST_WAIT;
               pending_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (frame_start_i) begin
               shadow_load = 1'b1;
               applied_d   = 1'b1;
               pending_d   = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            pending_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      paddle_x_d = shadow_load ? paddle_x_i : paddle_x_q;
      ball_x_d   = shadow_load ? ball_x_i   : ball_x_q;
      ball_y_d   = shadow_load ? ball_y_i   : ball_y_q;
      bricks_d   = shadow_load ? bricks_i   : bricks_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pending_q  <= 1'b0;
         applied_q  <= 1'b0;
         color_q    <= '0;
         paddle_x_q <= 10'd360;
         ball_x_q   <= 10'd396;
         ball_y_q   <= 10'd400;
         bricks_q   <= '1;
         col_q      <= '0;
         xoff_q     <= '0;
         row_q      <= '0;
         yoff_q     <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         applied_q  <= applied_d;
         color_q    <= color_d;
         paddle_x_q <= paddle_x_d;
         ball_x_q   <= ball_x_d;
         ball_y_q   <= ball_y_d;
         bricks_q   <= bricks_d;
         col_q      <= col_d;
         xoff_q     <= xoff_d;
         row_q      <= row_d;
         yoff_q     <= yoff_d;
      end
   end

   assign pending_o = pending_q;
   assign applied_o = applied_q;
   assign color_o   = color_q;

endmodule

// File: tb/tb_scene_renderer.sv
// Self-checking bench for scene_renderer: emulates the output stage counters and
// scoreboards every pixel of selected lines against a behavioural colour model.
module tb_scene_renderer;

   localparam int LINE_END  = 1056;
   localparam int FRAME_END = 628;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [10:0]  x_pixel_i;
   logic [9:0]   y_pixel_i;
   logic         frame_start_i;
   logic [9:0]   paddle_x_i;
   logic [9:0]   ball_x_i;
   logic [9:0]   ball_y_i;
   logic [127:0] bricks_i;
   logic         commit_i;
   logic         pending_o;
   logic         applied_o;
   logic [7:0]   color_o;

   always #5 clk = ~clk;

   scene_renderer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .x_pixel_i     (x_pixel_i),
      .y_pixel_i     (y_pixel_i),
      .frame_start_i (frame_start_i),
      .paddle_x_i    (paddle_x_i),
      .ball_x_i      (ball_x_i),
      .ball_y_i      (ball_y_i),
      .bricks_i      (bricks_i),
      .commit_i      (commit_i),
      .pending_o     (pending_o),
      .applied_o     (applied_o),
      .color_o       (color_o)
   );

   typedef struct {
      int         x;
      int         y;
      logic [7:0] exp;
   } pix_t;

   pix_t exp_q[$];
   pix_t mon_p;
   int   n_chk  = 0;
   int   n_pass = 0;

   // Reference copy of the shadow registers
   int           m_px;
   int           m_bx;
   int           m_by;
   logic [127:0] m_bricks;
   int           cx;
   int           cy;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
   endtask

   function automatic logic [7:0] model(input int x, input int y);
      int r;
      int c;
      if (x >= 800 || y >= 600) return 8'h00;
      if (x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 8'hFC;
      if (x >= m_px && x < m_px + 80 && y >= 560 && y < 570) return 8'hFF;
      if (y >= 40 && y < 40 + 8 * 20) begin
         r = (y - 40) / 20;
         c = x / 50;
         if (m_bricks[r * 16 + c] && (x % 50) < 48 && ((y - 40) % 20) < 18)
            return {3'(r), 3'(7 - r), 2'b10};
      end
`ifdef SCENE_RENDERER_BORDER_EN
      if (x < 8 || x >= 792 || y < 8) return 8'h92;
`endif
      return 8'h00;
   endfunction

   task automatic drive_xy();
      x_pixel_i = 11'(cx);
      y_pixel_i = 10'(cy);
   endtask

   // One pixel clock of the output stage; optionally queue the expected colour
   task automatic tick(input bit chk_en);
      pix_t p;
      @(posedge clk);
      #1;
      if (cx == LINE_END - 1) begin
         cx = 0;
         cy = (cy == FRAME_END - 1) ? 0 : cy + 1;
      end else begin
         cx = cx + 1;
      end
      drive_xy();
      if (chk_en) begin
         p.x   = cx;
         p.y   = cy;
         p.exp = model(cx, cy);
         exp_q.push_back(p);
      end
   endtask

   task automatic jump(input int x, input int y);
      @(posedge clk);
      #1;
      cx = x;
      cy = y;
      drive_xy();
   endtask

   task automatic run_line(input int y);
      int py;
      py = (y == 0) ? FRAME_END - 1 : y - 1;
      if (!(cx == LINE_END - 1 && cy == py)) jump(LINE_END - 1, py);
      repeat (LINE_END) tick(1'b1);
   endtask

   task automatic model_load();
      m_px     = int'(paddle_x_i);
      m_bx     = int'(ball_x_i);
      m_by     = int'(ball_y_i);
      m_bricks = bricks_i;
   endtask

   task automatic model_reset();
      m_px     = 360;
      m_bx     = 396;
      m_by     = 400;
      m_bricks = '1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_p = exp_q.pop_front();
         chk($sformatf("pix(%0d,%0d)", mon_p.x, mon_p.y), color_o, mon_p.exp);
      end
   end

   initial begin
      rst_n         = 1'b0;
      cx            = 0;
      cy            = 0;
      drive_xy();
      frame_start_i = 1'b0;
      commit_i      = 1'b0;
      paddle_x_i    = 10'd360;
      ball_x_i      = 10'd396;
      ball_y_i      = 10'd400;
      bricks_i      = '1;
      model_reset();

      repeat (3) @(negedge clk);
      chk("rst_color", color_o, 8'h00);
      chk("rst_pending", {7'b0, pending_o}, 8'd0);
      chk("rst_applied", {7'b0, applied_o}, 8'd0);
      rst_n = 1'b1;

      // Full brick grid from reset shadow, rows 0 and 1 including the gap lines
      for (int y = 40; y <= 60; y++) run_line(y);

      // Frame start with nothing pending does nothing
      frame_start_i = 1'b1;
      tick(1'b0);
      frame_start_i = 1'b0;
      @(negedge clk);
      chk("fs_only_applied", {7'b0, applied_o}, 8'd0);
      chk("fs_only_pending", {7'b0, pending_o}, 8'd0);

      // Two commits before the frame boundary; inputs taken at the boundary
      commit_i = 1'b1;
      tick(1'b0);
      commit_i = 1'b0;
      @(negedge clk);
      chk("commit1_pending", {7'b0, pending_o}, 8'd1);
      ball_x_i = 10'd50;
      ball_y_i = 10'd50;
      commit_i = 1'b1;
      tick(1'b0);
      commit_i = 1'b0;
      @(negedge clk);
      chk("commit2_pending", {7'b0, pending_o}, 8'd1);
      chk("commit2_applied", {7'b0, applied_o}, 8'd0);
      ball_x_i   = 10'd100;
      ball_y_i   = 10'd300;
      paddle_x_i = 10'd760;
      tick(1'b0);
      frame_start_i = 1'b1;
      tick(1'b0);
      frame_start_i = 1'b0;
      model_load();
      @(negedge clk);
      chk("load_applied", {7'b0, applied_o}, 8'd1);
      chk("load_pending", {7'b0, pending_o}, 8'd0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0);
         @(negedge clk);
         chk($sformatf("applied_pulse%0d", i), {7'b0, applied_o}, 8'd0);
      end

      // Ball at (100,300), paddle clipped at right edge, invisible lines and wraps
      run_line(300);
      run_line(307);
      run_line(308);
      run_line(560);
      run_line(569);
      run_line(570);
      run_line(599);
      run_line(600);
      run_line(627);
      run_line(0);

      // Commit and frame start together: immediate load, no pending
      ball_x_i   = 10'd400;
      ball_y_i   = 10'd560;
      paddle_x_i = 10'd360;
      bricks_i   = {$urandom, $urandom, $urandom, $urandom};
      commit_i      = 1'b1;
      frame_start_i = 1'b1;
      tick(1'b0);
      commit_i      = 1'b0;
      frame_start_i = 1'b0;
      model_load();
      @(negedge clk);
      chk("same_applied", {7'b0, applied_o}, 8'd1);
      chk("same_pending", {7'b0, pending_o}, 8'd0);
      tick(1'b0);
      @(negedge clk);
      chk("same_pending2", {7'b0, pending_o}, 8'd0);
      chk("same_applied2", {7'b0, applied_o}, 8'd0);

      // Ball over paddle, then a partly cleared brick grid
      run_line(560);
      run_line(567);
      run_line(568);
      for (int y = 40; y <= 45; y++) run_line(y);

      // Asynchronous reset in the middle of a visible line with a commit pending
      jump(399, 565);
      repeat (3) tick(1'b0);
      commit_i = 1'b1;
      tick(1'b0);
      commit_i = 1'b0;
      @(negedge clk);
      chk("pre_rst_pending", {7'b0, pending_o}, 8'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_color", color_o, 8'h00);
      chk("mid_rst_pending", {7'b0, pending_o}, 8'd0);
      chk("mid_rst_applied", {7'b0, applied_o}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run_line(560);
      run_line(40);
      run_line(41);

      repeat (2) @(negedge clk);
      chk("sb_drain", 8'(exp_q.size()), 8'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
